// File: rtl/fft256_bitrev_reorder_if.sv
// Sample stream bundle for the 256-point bit-reverse reorder buffer.
// di_*: bit-reversed input stream; do_*: natural-order output stream.
interface fft256_bitrev_reorder_if #(
  parameter int WIDTH = 16
);
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [7:0]       do_idx;
  logic             do_last;

  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im, do_idx, do_last
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im, do_idx, do_last
  );
endinterface

// File: rtl/fft256_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT bins in, natural order out.
// Ports: clock, reset (sync, active-high), bus (slave stream bundle).
module fft256_bitrev_reorder #(
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  fft256_bitrev_reorder_if.slave bus
);
  localparam int DW = 2 * WIDTH;

  typedef enum logic { IDLE, READ } rd_state_e;

  logic [DW-1:0] mem [2][256];

  logic [7:0] wcnt_q, wcnt_d;
  logic       wptr_q, wptr_d;
  logic [1:0] full_q, full_d;
  rd_state_e  state_q, state_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic       rbank_q, rbank_d;

  logic       rd_act;
  logic       rd_bank;
  logic [7:0] rd_addr;
  logic [7:0] waddr;

  logic             do_en_q;
  logic             do_last_q;
  logic [7:0]       do_idx_q;
  logic [WIDTH-1:0] do_re_q;
  logic [WIDTH-1:0] do_im_q;

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  always_comb begin
    waddr   = bitrev8(wcnt_q);
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    full_d  = full_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    rd_act  = 1'b0;
    rd_bank = rbank_q;
    rd_addr = rcnt_q;

    // Address 0 is issued in the same cycle the full flag is
    // first seen, so bin 0 leaves two cycles after the last write.
    unique case (state_q)
      IDLE: begin
        if (|full_q) begin
          rd_act  = 1'b1;
          // Both full: the write pointer bank was filled first.
          rd_bank = full_q[wptr_q] ? wptr_q : ~wptr_q;
          rd_addr = 8'd0;
          rbank_d = rd_bank;
          rcnt_d  = 8'd1;
          state_d = READ;
        end
      end
      READ: begin
        rd_act = 1'b1;
        rcnt_d = rcnt_q + 8'd1;
        if (rcnt_q == 8'hFF) begin
          full_d[rbank_q] = 1'b0;
          if (full_q[~rbank_q]) begin
            rbank_d = ~rbank_q;
            rcnt_d  = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    if (bus.di_en) begin
      wcnt_d = wcnt_q + 8'd1;
      if (wcnt_q == 8'hFF) begin
        full_d[wptr_q] = 1'b1;
        wptr_d         = ~wptr_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q  <= '0;
      wptr_q  <= 1'b0;
      full_q  <= '0;
      state_q <= IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      full_q  <= full_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.di_en) begin
      mem[wptr_q][waddr] <= {bus.di_re, bus.di_im};
    end
  end

  // The RAM read register doubles as the output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      do_en_q   <= 1'b0;
      do_last_q <= 1'b0;
      do_idx_q  <= '0;
      do_re_q   <= '0;
      do_im_q   <= '0;
    end else begin
      do_en_q   <= rd_act;
      do_last_q <= rd_act && (rd_addr == 8'hFF);
      if (rd_act) begin
        {do_re_q, do_im_q} <= mem[rd_bank][rd_addr];
        do_idx_q           <= rd_addr;
      end
    end
  end

  assign bus.do_en   = do_en_q;
  assign bus.do_last = do_last_q;
  assign bus.do_idx  = do_idx_q;
  assign bus.do_re   = do_re_q;
  assign bus.do_im   = do_im_q;
endmodule
